// File: rtl/mu_thermal_pkg.sv
// Shared constants and types for the thermal capture path.
// Holds pixel/lane geometry used by mu_pixel_packer and a byte-swap helper
// for sensors that deliver big-endian 16-bit samples.
package mu_thermal_pkg;

    localparam int MU_PIXEL_W    = 16;
    localparam int MU_PACK_LANES = 4;
    localparam int MU_FRAME_W    = 32;
    localparam int MU_FRAME_H    = 24;

    typedef logic [MU_PIXEL_W-1:0] mu_pixel_t;

    // Swap the two bytes of a 16-bit pixel (big-endian sensor to little-endian bus).
    function automatic mu_pixel_t mu_byte_swap(input mu_pixel_t p);
        return {p[7:0], p[15:8]};
    endfunction

endpackage

// File: rtl/mu_pixel_packer.sv
// mu_pixel_packer: packs LANES consecutive pixels into one wide word for the
// capture FIFO write port, flushing a partial word with a keep mask at end
// of frame. Build option MU_PIXEL_PACKER_SWAP_EN byte-swaps every accepted
// pixel before packing (requires PW == 16).
module mu_pixel_packer
    import mu_thermal_pkg::*;
#(
    parameter int PW    = MU_PIXEL_W,
    parameter int LANES = MU_PACK_LANES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PW-1:0]       in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [PW*LANES-1:0] out_data,
    output logic [LANES-1:0]    out_keep,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_done
);

    localparam int DW = PW * LANES;
    localparam int AW = PW * (LANES - 1);
    localparam int LW = $clog2(LANES);

    logic [AW-1:0]    r_acc;
    logic [LW-1:0]    r_lane;
    logic [DW-1:0]    r_out_data;
    logic [LANES-1:0] r_out_keep;
    logic             r_out_last;
    logic             r_out_valid;

    logic [PW-1:0]    w_pix;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_complete;
    logic             w_consume;
    logic [DW-1:0]    w_word;
    logic [LANES-1:0] w_keep;

`ifdef MU_PIXEL_PACKER_SWAP_EN
    assign w_pix = mu_byte_swap(in_data);
`else
    assign w_pix = in_data;
`endif

    // in_ready depends on output-register state only, never on in_valid/in_last.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_complete = (r_lane == LW'(LANES - 1)) || in_last;
    assign w_consume  = r_out_valid && out_ready;

    // Assemble the completed word: stored lanes below r_lane, new pixel at r_lane, zeros above.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            if (i < int'(r_lane)) begin
                w_word[i*PW +: PW] = r_acc[i*PW +: PW];
            end else begin
                w_word[i*PW +: PW] = '0;
            end
        end
        w_word[int'(r_lane)*PW +: PW] = w_pix;
        for (int i = 0; i < LANES; i++) begin
            w_keep[i] = (i <= int'(r_lane));
        end
    end

    // Accumulator and lane index: store non-completing pixels, restart at lane 0 on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_lane <= '0;
        end else if (w_accept && w_complete) begin
            r_lane <= '0;
        end else if (w_accept) begin
            r_acc[int'(r_lane)*PW +: PW] <= w_pix;
            r_lane                       <= r_lane + LW'(1);
        end else begin
            r_lane <= r_lane;
        end
    end

    // Output register: load on completion (even while the old word is consumed), hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && w_complete) begin
            r_out_data  <= w_word;
            r_out_keep  <= w_keep;
            r_out_last  <= in_last;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_keep   = r_out_keep;
    assign out_last   = r_out_last;
    assign out_valid  = r_out_valid;
    assign frame_done = w_consume && r_out_last;

endmodule

// File: tb/tb_mu_pixel_packer.sv
// Self-checking bench for mu_pixel_packer: directed vectors plus randomized
// backpressure, compared against a pixel-list reference model.
module tb_mu_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;

    mu_pixel_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    bit chk_en = 1'b0;

    // reference model: pixels of the word being gathered, plus the presented word
    logic [15:0] cur[$];
    logic [15:0] sent_q[$];
    word_t       got_q[$];
    bit          exp_valid = 1'b0;
    logic [63:0] exp_data = 64'd0;
    logic [3:0]  exp_keep = 4'd0;
    bit          exp_last = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sw(input logic [15:0] p);
`ifdef MU_PIXEL_PACKER_SWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    // one clock cycle: drive, check at negedge, advance the model, return after posedge
    task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                       input logic l, input logic o);
        bit acc;
        word_t w;
        rst = r; in_valid = v; in_data = d; in_last = l; out_ready = o;
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(!exp_valid || o));
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("frame_done", 64'(frame_done), 64'(exp_valid && o && exp_last));
            if (exp_valid) begin
                check("out_data", out_data, exp_data);
                check("out_keep", 64'(out_keep), 64'(exp_keep));
                check("out_last", 64'(out_last), 64'(exp_last));
            end
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (!r && out_valid === 1'b1 && o) begin
            w.d = out_data; w.k = out_keep; w.l = out_last;
            got_q.push_back(w);
        end
        if (r) begin
            cur.delete();
            exp_valid = 1'b0;
            exp_data  = 64'd0;
            exp_keep  = 4'd0;
            exp_last  = 1'b0;
        end else begin
            acc = v && (!exp_valid || o);
            if (exp_valid && o) exp_valid = 1'b0;
            if (acc) begin
                cur.push_back(sw(d));
                sent_q.push_back(sw(d));
                if (cur.size() == 4 || l) begin
                    exp_data = 64'd0;
                    foreach (cur[i]) exp_data = exp_data | (64'(cur[i]) << (16 * i));
                    exp_keep  = 4'((5'd1 << cur.size()) - 5'd1);
                    exp_last  = l;
                    exp_valid = 1'b1;
                    cur.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] e;
        logic [15:0] rx[$];
        int nl_sent;
        int nl_got;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0; out_ready = 1'b1;

        // reset and reset-state values
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // eight pixels, full words, no backpressure
        got_q.delete();
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 16'(i), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check("t1_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("t1_w0", got_q[0].d, {sw(16'd4), sw(16'd3), sw(16'd2), sw(16'd1)});
            check("t1_w1", got_q[1].d, {sw(16'd8), sw(16'd7), sw(16'd6), sw(16'd5)});
            check("t1_keep", 64'(got_q[1].k), 64'hF);
        end

        // six pixels, last on sixth -> partial word
        got_q.delete(); fd_cnt = 0;
        for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b1, 16'(i), 1'(i == 6), 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check("t2_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("t2_w1", got_q[1].d, {32'd0, sw(16'd6), sw(16'd5)});
            check("t2_keep", 64'(got_q[1].k), 64'h3);
            check("t2_last", 64'(got_q[1].l), 64'd1);
        end
        check("t2_frame_done", 64'(fd_cnt), 64'd1);

        // in_last at lane 0
        got_q.delete();
        cyc(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check("t3_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            check("t3_data", got_q[0].d, {48'd0, sw(16'hABCD)});
            check("t3_keep", 64'(got_q[0].k), 64'h1);
        end

        // reset after two pixels discards the partial word
        got_q.delete();
        cyc(1'b0, 1'b1, 16'h0101, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h0202, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check("t4_no_word", 64'(got_q.size()), 64'd0);
        for (int i = 9; i <= 12; i++) cyc(1'b0, 1'b1, 16'(i), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check("t4_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            check("t4_data", got_q[0].d, {sw(16'd12), sw(16'd11), sw(16'd10), sw(16'd9)});
            check("t4_keep", 64'(got_q[0].k), 64'hF);
        end

        // byte-order vector
        got_q.delete();
        cyc(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h5678, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h9ABC, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'hDEF0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
`ifdef MU_PIXEL_PACKER_SWAP_EN
        e = 64'hF0DEBC9A78563412;
`else
        e = 64'hDEF09ABC56781234;
`endif
        check("t5_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) check("t5_data", got_q[0].d, e);

        // randomized stall patterns with stream scoreboard
        got_q.delete(); sent_q.delete();
        for (int s = 0; s < 100; s++) begin
            int k0 = $urandom_range(1, 6);
            int k1 = $urandom_range(1, 6);
            for (int c = 0; c < k0 + k1; c++) begin
                cyc(1'b0, 1'(($urandom_range(0, 3)) != 0), 16'($urandom),
                    1'(($urandom_range(0, 7)) == 0), 1'(c >= k0));
            end
        end
        for (int i = 0; i < 4 && cur.size() != 0; i++) cyc(1'b0, 1'b1, 16'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        rx.delete();
        nl_got = 0;
        foreach (got_q[i]) begin
            for (int j = 0; j < 4; j++) if (got_q[i].k[j]) rx.push_back(got_q[i].d[16*j +: 16]);
            if (got_q[i].l) nl_got++;
        end
        check("sb_count", 64'(rx.size()), 64'(sent_q.size()));
        if (rx.size() == sent_q.size()) begin
            foreach (rx[i]) check("sb_pixel", 64'(rx[i]), 64'(sent_q[i]));
        end
        nl_sent = 0;
        foreach (got_q[i]) if (got_q[i].l) nl_sent = nl_sent + 0;
        check("sb_nonempty", 64'(sent_q.size() > 0), 64'd1);
        check("sb_last_seen", 64'(nl_got > 0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
